// File: rtl/if_id_reg_if.sv
// IF/ID boundary bundle: fetch/hazard-side controls in, registered instruction and decode fields out.
// master = fetch + hazard unit side, slave = the IF/ID register itself.
interface if_id_reg_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc_plus4;
  logic             id_stall;
  logic             id_flush;
  logic             if_ready;
  logic             id_valid;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc_plus4;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic [4:0]       id_shamt;
  logic [5:0]       id_funct;
  logic [15:0]      id_imm16;
  logic [1:0]       id_ext_type;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output if_valid, if_instr, if_pc_plus4, id_stall, id_flush,
    input  if_ready, id_valid, id_instr, id_pc_plus4, id_opcode, id_rs, id_rt,
           id_rd, id_shamt, id_funct, id_imm16, id_ext_type, stall_cnt
  );

  modport slave (
    input  if_valid, if_instr, if_pc_plus4, id_stall, id_flush,
    output if_ready, id_valid, id_instr, id_pc_plus4, id_opcode, id_rs, id_rt,
           id_rd, id_shamt, id_funct, id_imm16, id_ext_type, stall_cnt
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds fetched instruction and PC+4 with stall/flush control,
// splits the instruction into decode fields and counts stall cycles (saturating).
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_PC4 = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  if_id_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [5:0]       OP_ANDI = 6'b001100;
  localparam logic [5:0]       OP_ORI  = 6'b001101;
  localparam logic [5:0]       OP_XORI = 6'b001110;
  localparam logic [5:0]       OP_LUI  = 6'b001111;

  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]       ext_type;

  // Next-state: flush beats stall beats accept; anything else inserts a bubble.
  always_comb begin
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_plus4_d  = pc_plus4_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.id_flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (bus.id_stall) begin
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (bus.if_valid) begin
      valid_d    = 1'b1;
      instr_d    = bus.if_instr;
      pc_plus4_d = bus.if_pc_plus4;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      pc_plus4_q  <= RESET_PC4;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_plus4_q  <= pc_plus4_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Logical immediates zero-extend, lui places the immediate in the upper half.
  always_comb begin
    ext_type = 2'b00;
    case (instr_q[31:26])
      OP_ANDI, OP_ORI, OP_XORI: ext_type = 2'b11;
      OP_LUI:                   ext_type = 2'b01;
      default:                  ext_type = 2'b00;
    endcase
  end

  assign bus.if_ready    = ~bus.id_stall | bus.id_flush;
  assign bus.id_valid    = valid_q;
  assign bus.id_instr    = instr_q;
  assign bus.id_pc_plus4 = pc_plus4_q;
  assign bus.id_opcode   = instr_q[31:26];
  assign bus.id_rs       = instr_q[25:21];
  assign bus.id_rt       = instr_q[20:16];
  assign bus.id_rd       = instr_q[15:11];
  assign bus.id_shamt    = instr_q[10:6];
  assign bus.id_funct    = instr_q[5:0];
  assign bus.id_imm16    = instr_q[15:0];
  assign bus.id_ext_type = ext_type;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
